// File: rtl/memarbiter.sv
// memarbiter: shares one external-memory port among the write buffer (WB),
// the data cache (D) and the instruction cache (I).
//
// It picks the owner of the bus, drives memen/memrwb and the one-hot grant
// that steers the address/data/byte-enable muxes, and inserts one idle
// turnaround cycle when a read follows a write. It also returns memdone to
// the owner as a per-requester done pulse, aborts hung transfers with buserr,
// and promotes a cache above the WB once that cache has waited too long.
//
// Ports
//   ph1      in   system clock, rising edge
//   reset    in   synchronous active-high reset
//   wbreq    in   WB request (always a write), held until wbdone
//   dreq     in   D request, held until ddone; drwb: 1 read / 0 write
//   ireq     in   I request, held until idone; irwb: 1 read / 0 write
//   memdone  in   memory transfer complete
//   grant    out  one-hot owner {I,D,WB}, 000 when idle
//   memen    out  memory enable (high only while the transfer is on the bus)
//   memrwb   out  memory direction, 1 read / 0 write (1 when idle)
//   wbdone/ddone/idone out  one-cycle complete/abort pulse to the owner
//   buserr   out  one-cycle pulse when a transfer is aborted by timeout
module memarbiter #(
    parameter int TIMEOUT = 255,
    parameter int STARVE  = 15
) (
    input  logic       ph1,
    input  logic       reset,
    input  logic       wbreq,
    input  logic       dreq,
    input  logic       drwb,
    input  logic       ireq,
    input  logic       irwb,
    input  logic       memdone,
    output logic [2:0] grant,
    output logic       memen,
    output logic       memrwb,
    output logic       wbdone,
    output logic       ddone,
    output logic       idone,
    output logic       buserr
);

    localparam logic [7:0] HITCNT   = 8'(TIMEOUT - 1);
    localparam logic [3:0] STARVE_C = 4'(STARVE);

    typedef enum logic [1:0] {IDLE, TURN, BUSY} state_t;

    state_t     state, state_nxt;
    logic [2:0] grant_nxt;
    logic       memrwb_nxt;
    logic       lastwr, lastwr_nxt;
    logic [7:0] waitcnt, waitcnt_nxt;
    logic [3:0] scnt_d, scnt_i;
    logic       promo_d, promo_i;
    logic       hit, finish;
    logic [2:0] winner;
    logic       winrd;

    assign promo_d = (scnt_d == STARVE_C);
    assign promo_i = (scnt_i == STARVE_C);

    // Promoted caches beat the WB; otherwise WB > D > I.
    always_comb begin
        winner = 3'b000;
        winrd  = 1'b1;
        if (promo_d && dreq) begin
            winner = 3'b010;
            winrd  = drwb;
        end else if (promo_i && ireq) begin
            winner = 3'b100;
            winrd  = irwb;
        end else if (wbreq) begin
            winner = 3'b001;
            winrd  = 1'b0;
        end else if (dreq) begin
            winner = 3'b010;
            winrd  = drwb;
        end else if (ireq) begin
            winner = 3'b100;
            winrd  = irwb;
        end
    end

    assign memen  = (state == BUSY);
    assign hit    = (state == BUSY) && (waitcnt == HITCNT);
    assign finish = (state == BUSY) && (memdone || hit);

    // memdone on the timeout cycle counts as a normal completion.
    assign buserr = hit && !memdone;
    assign wbdone = grant[0] && finish;
    assign ddone  = grant[1] && finish;
    assign idone  = grant[2] && finish;

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        memrwb_nxt  = memrwb;
        lastwr_nxt  = lastwr;
        waitcnt_nxt = waitcnt;
        case (state)
            IDLE: begin
                if (winner != 3'b000) begin
                    grant_nxt   = winner;
                    memrwb_nxt  = winrd;
                    waitcnt_nxt = 8'd0;
                    // A read right after a write needs a dead cycle so the
                    // memory data drivers can swap direction.
                    state_nxt   = (lastwr && winrd) ? TURN : BUSY;
                end
            end
            TURN: begin
                state_nxt = BUSY;
            end
            BUSY: begin
                if (finish) begin
                    state_nxt   = IDLE;
                    grant_nxt   = 3'b000;
                    memrwb_nxt  = 1'b1;
                    waitcnt_nxt = 8'd0;
                    lastwr_nxt  = !memrwb;
                end else begin
                    waitcnt_nxt = waitcnt + 8'd1;
                end
            end
            default: begin
                state_nxt  = IDLE;
                grant_nxt  = 3'b000;
                memrwb_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge ph1) begin
        if (reset) begin
            state   <= IDLE;
            grant   <= 3'b000;
            memrwb  <= 1'b1;
            lastwr  <= 1'b0;
            waitcnt <= 8'd0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            memrwb  <= memrwb_nxt;
            lastwr  <= lastwr_nxt;
            waitcnt <= waitcnt_nxt;
        end
    end

    // Starvation counters run in every state and saturate at STARVE.
    always_ff @(posedge ph1) begin
        if (reset || !dreq || grant[1]) begin
            scnt_d <= 4'd0;
        end else if (scnt_d != STARVE_C) begin
            scnt_d <= scnt_d + 4'd1;
        end
        if (reset || !ireq || grant[2]) begin
            scnt_i <= 4'd0;
        end else if (scnt_i != STARVE_C) begin
            scnt_i <= scnt_i + 4'd1;
        end
    end

endmodule

// File: tb/tb_memarbiter.sv
// Testbench for memarbiter: vector table, hand-written corner sequences and a
// randomized run against a transaction-level reference model.
module tb_memarbiter;

    localparam int TIMEOUT = 255;
    localparam int STARVE  = 15;

    logic       ph1 = 1'b0;
    logic       reset = 1'b1;
    logic       wbreq = 1'b0, dreq = 1'b0, drwb = 1'b0, ireq = 1'b0, irwb = 1'b0, memdone = 1'b0;
    logic [2:0] grant;
    logic       memen, memrwb, wbdone, ddone, idone, buserr;

    int checks = 0;
    int errors = 0;

    memarbiter #(.TIMEOUT(TIMEOUT), .STARVE(STARVE)) dut (
        .ph1(ph1), .reset(reset),
        .wbreq(wbreq), .dreq(dreq), .drwb(drwb), .ireq(ireq), .irwb(irwb),
        .memdone(memdone),
        .grant(grant), .memen(memen), .memrwb(memrwb),
        .wbdone(wbdone), .ddone(ddone), .idone(idone), .buserr(buserr)
    );

    always #5 ph1 = ~ph1;

    // {grant[2:0], memen, memrwb, wbdone, ddone, idone, buserr}
    function automatic logic [8:0] obs();
        return {grant, memen, memrwb, wbdone, ddone, idone, buserr};
    endfunction

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %b want %b (g,en,rwb,wbd,dd,id,err)", name, act, want);
        end
    endtask

    task automatic checki(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, want);
        end
    endtask

    task automatic do_reset();
        @(negedge ph1);
        reset = 1'b1;
        wbreq = 1'b0; dreq = 1'b0; drwb = 1'b0; ireq = 1'b0; irwb = 1'b0; memdone = 1'b0;
        @(negedge ph1);
        #2;
        check("reset", obs(), 9'b000_0_1_0000);
        reset = 1'b0;
    endtask

    typedef struct {
        logic       wb, d, drw, i, irw, md;
        logic [8:0] want;
    } vec_t;

    vec_t tbl[$];

    // Reference model state (transaction level)
    int m_owner;   // 0 none, 1 WB, 2 D, 3 I
    bit m_turn, m_rd, m_lastwr;
    int m_el, m_sd, m_si;

    initial begin
        int first, wbd, busy, got, old_owner, w;
        bit act, hitm, fin;
        bit rq[1:3];
        bit dn[1:3];
        int order[$];
        logic [2:0] eg;
        logic [8:0] want;

        // ---------------- vector table: single WB, then WB/D/I together
        tbl.push_back('{1,0,0,0,0,0, 9'b000_0_1_0000});
        tbl.push_back('{1,0,0,0,0,0, 9'b001_1_0_0000});
        tbl.push_back('{1,0,0,0,0,0, 9'b001_1_0_0000});
        tbl.push_back('{1,0,0,0,0,1, 9'b001_1_0_1000});
        tbl.push_back('{0,0,0,0,0,0, 9'b000_0_1_0000});
        tbl.push_back('{1,1,1,1,1,0, 9'b000_0_1_0000});
        tbl.push_back('{1,1,1,1,1,1, 9'b001_1_0_1000});
        tbl.push_back('{0,1,1,1,1,0, 9'b000_0_1_0000});
        tbl.push_back('{0,1,1,1,1,0, 9'b010_0_1_0000});
        tbl.push_back('{0,1,1,1,1,1, 9'b010_1_1_0100});
        tbl.push_back('{0,0,0,1,1,0, 9'b000_0_1_0000});
        tbl.push_back('{0,0,0,1,1,1, 9'b100_1_1_0010});
        tbl.push_back('{0,0,0,0,0,0, 9'b000_0_1_0000});

        do_reset();
        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge ph1);
            wbreq = tbl[k].wb; dreq = tbl[k].d; drwb = tbl[k].drw;
            ireq = tbl[k].i; irwb = tbl[k].irw; memdone = tbl[k].md;
            #2;
            check($sformatf("vec%0d", k), obs(), tbl[k].want);
        end

        // ---------------- starvation: WB hogs the bus, D must get in
        do_reset();
        first = -1; wbd = 0;
        for (int c = 0; c < 40 && first < 0; c++) begin
            @(negedge ph1);
            wbreq = 1'b1; dreq = 1'b1; drwb = 1'b1; ireq = 1'b0;
            memdone = memen && (grant == 3'b001);
            #2;
            if (grant == 3'b010) begin
                first = c;
                check("starve_turn", obs(), 9'b010_0_1_0000);
            end else if (wbdone) begin
                wbd++;
            end
        end
        checki("starve_first_cycle", first, 17);
        checki("starve_wb_before", wbd, 8);
        @(negedge ph1);
        wbreq = 1'b0; memdone = 1'b1;
        #2;
        check("starve_ddone", obs(), 9'b010_1_1_0100);
        @(negedge ph1);
        dreq = 1'b0; memdone = 1'b0;
        #2;
        check("starve_idle", obs(), 9'b000_0_1_0000);

        // ---------------- timeout with no memdone
        do_reset();
        busy = 0; got = -1;
        for (int c = 0; c < 300 && got < 0; c++) begin
            @(negedge ph1);
            dreq = 1'b1; drwb = 1'b1; memdone = 1'b0;
            if (memen) busy++;
            #2;
            if (ddone || buserr) begin
                got = busy;
                check("timeout_pulse", obs(), 9'b010_1_1_0101);
            end
        end
        checki("timeout_cycle", got, TIMEOUT);
        @(negedge ph1);
        dreq = 1'b0;
        #2;
        check("timeout_after", obs(), 9'b000_0_1_0000);

        // ---------------- memdone exactly on the timeout cycle
        do_reset();
        busy = 0; got = -1;
        for (int c = 0; c < 300 && got < 0; c++) begin
            @(negedge ph1);
            dreq = 1'b1; drwb = 1'b1;
            if (memen) busy++;
            memdone = memen && (busy == TIMEOUT);
            #2;
            if (ddone || buserr) begin
                got = busy;
                check("tmo_memdone_pulse", obs(), 9'b010_1_1_0100);
            end
        end
        checki("tmo_memdone_cycle", got, TIMEOUT);
        @(negedge ph1);
        dreq = 1'b0; memdone = 1'b0;
        #2;
        check("tmo_memdone_after", obs(), 9'b000_0_1_0000);

        // ---------------- reset during BUSY; lastwr must be cleared
        do_reset();
        @(negedge ph1); wbreq = 1'b1; #2;                  // IDLE
        @(negedge ph1); memdone = 1'b1; #2;                // BUSY, completes
        check("rst_wb1", obs(), 9'b001_1_0_1000);
        @(negedge ph1); wbreq = 1'b0; memdone = 1'b0; #2;  // IDLE, lastwr=1
        @(negedge ph1); wbreq = 1'b1; #2;                  // IDLE
        @(negedge ph1); reset = 1'b1; #2;                  // BUSY, reset
        check("rst_busy", obs(), 9'b001_1_0_0000);
        @(negedge ph1); reset = 1'b0; wbreq = 1'b0; dreq = 1'b1; drwb = 1'b1; #2;
        check("rst_after", obs(), 9'b000_0_1_0000);
        @(negedge ph1); #2;                                // no TURN: lastwr cleared
        check("rst_noturn", obs(), 9'b010_1_1_0000);
        @(negedge ph1); memdone = 1'b1; #2;
        check("rst_ddone", obs(), 9'b010_1_1_0100);
        @(negedge ph1); dreq = 1'b0; memdone = 1'b0; #2;
        check("rst_idle", obs(), 9'b000_0_1_0000);

        // ---------------- randomized run against the reference model
        do_reset();
        m_owner = 0; m_turn = 0; m_rd = 1; m_lastwr = 0; m_el = 0; m_sd = 0; m_si = 0;
        for (int r = 1; r <= 3; r++) begin rq[r] = 0; dn[r] = 0; end
        for (int c = 0; c < 3000; c++) begin
            @(negedge ph1);
            for (int r = 1; r <= 3; r++) begin
                if (rq[r] && dn[r]) begin
                    rq[r] = 0;
                end else if (!rq[r] && $urandom_range(0, 3) == 0) begin
                    rq[r] = 1;
                    if (r == 2) drwb = 1'($urandom_range(0, 1));
                    if (r == 3) irwb = 1'($urandom_range(0, 1));
                end
            end
            wbreq = rq[1]; dreq = rq[2]; ireq = rq[3];
            memdone = ($urandom_range(0, 3) == 0);
            #2;

            act  = (m_owner != 0) && !m_turn;
            hitm = act && (m_el == TIMEOUT - 1);
            fin  = act && (memdone || hitm);
            eg   = (m_owner == 0) ? 3'b000 : 3'(1 << (m_owner - 1));
            want = {eg, act, (m_owner == 0) ? 1'b1 : m_rd,
                    fin && m_owner == 1, fin && m_owner == 2, fin && m_owner == 3,
                    hitm && !memdone};
            check($sformatf("rand%0d", c), obs(), want);
            for (int r = 1; r <= 3; r++) dn[r] = fin && (m_owner == r);

            // advance model one clock
            old_owner = m_owner;
            if (m_owner == 0) begin
                order.delete();
                if (m_sd == STARVE) order.push_back(2);
                if (m_si == STARVE) order.push_back(3);
                order.push_back(1); order.push_back(2); order.push_back(3);
                w = 0;
                foreach (order[k]) if (w == 0 && rq[order[k]]) w = order[k];
                if (w != 0) begin
                    m_owner = w;
                    m_rd    = (w == 1) ? 1'b0 : (w == 2) ? drwb : irwb;
                    m_turn  = m_lastwr && m_rd;
                    m_el    = 0;
                end
            end else if (m_turn) begin
                m_turn = 0;
            end else if (fin) begin
                m_lastwr = !m_rd;
                m_owner  = 0;
                m_rd     = 1;
            end else begin
                m_el++;
            end
            m_sd = (!dreq || old_owner == 2) ? 0 : ((m_sd < STARVE) ? m_sd + 1 : STARVE);
            m_si = (!ireq || old_owner == 3) ? 0 : ((m_si < STARVE) ? m_si + 1 : STARVE);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
